// File: rtl/multi_word_add_pkg.sv
// Shared FSM encoding for the multi-word add sequencer.
package multi_word_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'(S_IDLE);
  localparam logic [1:0] ST_RUN   = 2'(S_RUN);
  localparam logic [1:0] ST_DRAIN = 2'(S_DRAIN);

  // Word counter holds 0..nrOfWords without wrapping.
  function automatic int unsigned cnt_width(input int unsigned words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/multi_word_add_sequencer_if.sv
// Operand/result valid-ready streams of the multi-word add sequencer.
interface multi_word_add_sequencer_if #(
  parameter int unsigned nrOfBits = 16
);
  logic                opValid;
  logic                opReady;
  logic [nrOfBits-1:0] opA;
  logic [nrOfBits-1:0] opB;
  logic                resValid;
  logic                resReady;
  logic [nrOfBits-1:0] result;

  modport master (
    output opValid, opA, opB, resReady,
    input  opReady, resValid, result
  );

  modport slave (
    input  opValid, opA, opB, resReady,
    output opReady, resValid, result
  );
endinterface

// File: rtl/Adder.sv
// Word adder: sum = dataA + dataB + carryIn, widened to extendedBits.
module Adder #(
  parameter int unsigned nrOfBits     = 16,
  parameter int unsigned extendedBits = nrOfBits + 1
) (
  input  logic [nrOfBits-1:0]     dataA,
  input  logic [nrOfBits-1:0]     dataB,
  input  logic                    carryIn,
  output logic [extendedBits-1:0] sum
);
  assign sum = extendedBits'(dataA) + extendedBits'(dataB) + extendedBits'(carryIn);
endmodule

// File: rtl/multi_word_add_sequencer.sv
// Adds two nrOfWords-word operands LS word first, one word per cycle.
// Optional subtract mode: define MULTI_WORD_ADD_SUB_EN.
module multi_word_add_sequencer
  import multi_word_add_pkg::*;
#(
  parameter int unsigned nrOfBits  = 16,
  parameter int unsigned nrOfWords = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       carryIn,
`ifdef MULTI_WORD_ADD_SUB_EN
  input  logic                       sub,
`endif
  multi_word_add_sequencer_if.slave  bus,
  output logic                       carryOut,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CW = cnt_width(nrOfWords);
  localparam int unsigned XW = nrOfBits + 1;

  logic [1:0]          state, state_nxt;
  logic                carry;
  logic [CW-1:0]       count;
  logic                res_valid;
  logic [nrOfBits-1:0] result_q;
  logic                ready;
  logic                op_xfer, res_xfer, last_word;
  logic                carry_init;
  logic [nrOfBits-1:0] opb_eff;
  logic [XW-1:0]       sum;

`ifdef MULTI_WORD_ADD_SUB_EN
  logic sub_q;
  // Subtract as A + ~B + !borrow.
  assign opb_eff    = sub_q ? ~bus.opB : bus.opB;
  assign carry_init = sub ? ~carryIn : carryIn;

  always_ff @(posedge clock) begin
    if (reset)
      sub_q <= 1'b0;
    else if (state == ST_IDLE && start)
      sub_q <= sub;
  end
`else
  assign opb_eff    = bus.opB;
  assign carry_init = carryIn;
`endif

  assign last_word = (count == CW'(nrOfWords - 1));
  assign op_xfer   = bus.opValid && ready;
  assign res_xfer  = res_valid && bus.resReady;

  assign bus.opReady  = ready;
  assign bus.resValid = res_valid;
  assign bus.result   = result_q;
  assign carryOut     = carry;

  Adder #(
    .nrOfBits     (nrOfBits),
    .extendedBits (XW)
  ) u_adder (
    .dataA   (bus.opA),
    .dataB   (opb_eff),
    .carryIn (carry),
    .sum     (sum)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next state plus handshake decode; reset masks any transfer.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        ready = !res_valid || bus.resReady;
        if (bus.opValid && ready && last_word) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (res_valid && bus.resReady) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      ready = 1'b0;
      done  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      carry     <= 1'b0;
      count     <= '0;
      res_valid <= 1'b0;
      result_q  <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        carry <= carry_init;
        count <= '0;
      end
      if (op_xfer) begin
        {carry, result_q} <= sum;
        res_valid         <= 1'b1;
        count             <= count + CW'(1);
      end else if (res_xfer) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_word_add_sequencer.sv
// Directed bench for multi_word_add_sequencer (4-word and 1-word instances).
module tb_multi_word_add_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, start, carryIn, start1, carryIn1;
  logic carryOut, busy, done, carryOut1, busy1, done1;
`ifdef MULTI_WORD_ADD_SUB_EN
  logic sub, sub1;
`endif

  int checks = 0;
  int errors = 0;

  multi_word_add_sequencer_if #(.nrOfBits(16)) bus4 ();
  multi_word_add_sequencer_if #(.nrOfBits(16)) bus1 ();

  multi_word_add_sequencer #(.nrOfBits(16), .nrOfWords(4)) u_dut4 (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .carryIn  (carryIn),
`ifdef MULTI_WORD_ADD_SUB_EN
    .sub      (sub),
`endif
    .bus      (bus4),
    .carryOut (carryOut),
    .busy     (busy),
    .done     (done)
  );

  multi_word_add_sequencer #(.nrOfBits(16), .nrOfWords(1)) u_dut1 (
    .clock    (clock),
    .reset    (reset),
    .start    (start1),
    .carryIn  (carryIn1),
`ifdef MULTI_WORD_ADD_SUB_EN
    .sub      (sub1),
`endif
    .bus      (bus1),
    .carryOut (carryOut1),
    .busy     (busy1),
    .done     (done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Present one word pair to the 4-word DUT, transfer it, check the registered sum.
  task automatic word(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp, input string tag);
    bus4.opA     = a;
    bus4.opB     = b;
    bus4.opValid = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(bus4.opReady), 32'd1);
    tick();
    chk({tag, "_result"}, 32'(bus4.result), 32'(exp));
    chk({tag, "_valid"}, 32'(bus4.resValid), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; carryIn = 1'b0; start1 = 1'b0; carryIn1 = 1'b0;
`ifdef MULTI_WORD_ADD_SUB_EN
    sub = 1'b0; sub1 = 1'b0;
`endif
    bus4.opValid = 1'b0; bus4.opA = '0; bus4.opB = '0; bus4.resReady = 1'b0;
    bus1.opValid = 1'b0; bus1.opA = '0; bus1.opB = '0; bus1.resReady = 1'b0;
    @(negedge clock);
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bus4.resValid), 32'd0);
    chk("rst_result", 32'(bus4.result), 32'd0);
    chk("rst_carry", 32'(carryOut), 32'd0);
    chk("rst_ready", 32'(bus4.opReady), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    reset = 1'b0;

    // FFFF_FFFF_FFFF_FFFF + 1, consumer always ready
    carryIn = 1'b0; start = 1'b1; bus4.resReady = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid0", 32'(bus4.resValid), 32'd0);
    word(16'hFFFF, 16'h0001, 16'h0000, "t1_w0");
    word(16'hFFFF, 16'h0000, 16'h0000, "t1_w1");
    word(16'hFFFF, 16'h0000, 16'h0000, "t1_w2");
    word(16'hFFFF, 16'h0000, 16'h0000, "t1_w3");
    bus4.opValid = 1'b0;
    #1;
    chk("t1_ready_drain", 32'(bus4.opReady), 32'd0);
    chk("t1_carry", 32'(carryOut), 32'd1);
    chk("t1_done", 32'(done), 32'd1);
    tick();
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_valid_off", 32'(bus4.resValid), 32'd0);
    chk("t1_carry_hold", 32'(carryOut), 32'd1);

    // Same sum with a 3-cycle consumer stall after word 1; start pulsed mid-stall
    start = 1'b1;
    tick();
    start = 1'b0;
    word(16'hFFFF, 16'h0001, 16'h0000, "t2_w0");
    word(16'hFFFF, 16'h0000, 16'h0000, "t2_w1");
    bus4.opA = 16'hFFFF; bus4.opB = 16'h0000; bus4.resReady = 1'b0;
    #1;
    chk("t2_stall_ready", 32'(bus4.opReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start = 1'b1;
        carryIn = 1'b0;
      end
      tick();
      start = 1'b0;
      chk("t2_stall_result", 32'(bus4.result), 32'h0000);
      chk("t2_stall_valid", 32'(bus4.resValid), 32'd1);
      chk("t2_stall_ready", 32'(bus4.opReady), 32'd0);
    end
    bus4.resReady = 1'b1;
    word(16'hFFFF, 16'h0000, 16'h0000, "t2_w2");
    word(16'hFFFF, 16'h0000, 16'h0000, "t2_w3");
    bus4.opValid = 1'b0;
    #1;
    chk("t2_carry", 32'(carryOut), 32'd1);
    chk("t2_done", 32'(done), 32'd1);
    tick();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_done_off", 32'(done), 32'd0);

    // Reset during the word-2 transfer, then a fresh operation
    start = 1'b1;
    tick();
    start = 1'b0;
    word(16'hFFFF, 16'h0001, 16'h0000, "t3_w0");
    word(16'hFFFF, 16'h0000, 16'h0000, "t3_w1");
    bus4.opA = 16'hFFFF; bus4.opB = 16'h0000; reset = 1'b1;
    tick();
    chk("t3_rst_busy", 32'(busy), 32'd0);
    chk("t3_rst_valid", 32'(bus4.resValid), 32'd0);
    chk("t3_rst_carry", 32'(carryOut), 32'd0);
    chk("t3_rst_result", 32'(bus4.result), 32'd0);
    reset = 1'b0; bus4.opValid = 1'b0;
    carryIn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    word(16'h0004, 16'h1234, 16'h1239, "t3_w0b");
    word(16'h0003, 16'h0000, 16'h0003, "t3_w1b");
    word(16'h0002, 16'h0000, 16'h0002, "t3_w2b");
    word(16'h0001, 16'h0000, 16'h0001, "t3_w3b");
    bus4.opValid = 1'b0;
    #1;
    chk("t3_carry", 32'(carryOut), 32'd0);
    chk("t3_done", 32'(done), 32'd1);
    tick();
    chk("t3_idle", 32'(busy), 32'd0);

    // Single-word instance: 8000 + 8000 + 1
    bus1.resReady = 1'b1; carryIn1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    bus1.opA = 16'h8000; bus1.opB = 16'h8000; bus1.opValid = 1'b1;
    #1;
    chk("t4_ready", 32'(bus1.opReady), 32'd1);
    tick();
    bus1.opValid = 1'b0;
    #1;
    chk("t4_result", 32'(bus1.result), 32'h0001);
    chk("t4_valid", 32'(bus1.resValid), 32'd1);
    chk("t4_carry", 32'(carryOut1), 32'd1);
    chk("t4_done", 32'(done1), 32'd1);
    chk("t4_ready_drain", 32'(bus1.opReady), 32'd0);
    tick();
    chk("t4_idle", 32'(busy1), 32'd0);
    chk("t4_done_off", 32'(done1), 32'd0);

`ifdef MULTI_WORD_ADD_SUB_EN
    // 5 - 7 over four words: borrow out
    sub = 1'b1; carryIn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    word(16'h0005, 16'h0007, 16'hFFFE, "t5_w0");
    word(16'h0000, 16'h0000, 16'hFFFF, "t5_w1");
    word(16'h0000, 16'h0000, 16'hFFFF, "t5_w2");
    word(16'h0000, 16'h0000, 16'hFFFF, "t5_w3");
    bus4.opValid = 1'b0;
    #1;
    chk("t5_carry", 32'(carryOut), 32'd0);
    chk("t5_done", 32'(done), 32'd1);
    tick();
    sub = 1'b0;
    chk("t5_idle", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_word_add_sequencer.md
MULTI_WORD_ADD_SEQUENCER -- requirements
Module: multi_word_add_sequencer

Interface
REQ-001 SHALL have parameter nrOfBits, default 16: width of one operand word.
REQ-002 SHALL have parameter nrOfWords, default 4: words per operation, range 1..256.
REQ-003 SHALL have port clock  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port start  in  1: begin an operation; sampled only in IDLE.
REQ-006 SHALL have port carryIn  in  1: carry into word 0; captured with start.
REQ-007 SHALL have port opValid  in  1: opA/opB hold a valid word pair.
REQ-008 SHALL have port opReady  out  1: sequencer accepts the word pair this cycle.
REQ-009 SHALL have ports opA, opB  in  nrOfBits: operand words, least-significant word first.
REQ-010 SHALL have port resValid  out  1: result holds a valid sum word.
REQ-011 SHALL have port resReady  in  1: consumer accepts the result word.
REQ-012 SHALL have port result  out  nrOfBits: registered sum word.
REQ-013 SHALL have port carryOut  out  1: final carry; valid while done=1.
REQ-014 SHALL have port busy  out  1: high in every state except IDLE.
REQ-015 SHALL have port done  out  1: one-cycle pulse when the last result word is consumed.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-017 IDLE->RUN on start=1: carry register <= carryIn (inverted per REQ-031), word counter <= 0.
REQ-018 In RUN, opReady SHALL be 1 when (!resValid || resReady), else 0; combinational, no bubble.
REQ-019 Operand transfer = opValid && opReady; on transfer {carry, result} <= opA + opB + carry, resValid <= 1, counter increments.
REQ-020 Latency: result word N SHALL appear with resValid one cycle after operand word N transfers.
REQ-021 Result transfer = resValid && resReady; resValid SHALL clear unless a new operand transfers the same cycle.
REQ-022 Simultaneous operand and result transfers SHALL sustain one word per cycle.
REQ-023 result SHALL hold stable while resValid=1 and resReady=0.
REQ-024 On transfer of word nrOfWords-1, FSM SHALL go RUN->DRAIN; opReady SHALL be 0 in DRAIN and IDLE.
REQ-025 DRAIN->IDLE on the last result transfer; done SHALL pulse 1 that cycle.
REQ-026 carryOut SHALL equal the carry register; it holds until the next start.
REQ-027 start while busy SHALL be ignored.
REQ-028 nrOfWords=1: first transfer SHALL go directly RUN->DRAIN.
REQ-029 Word counter width SHALL be ceil(log2(nrOfWords))+1; no wrap within an operation.

Reset
REQ-030 reset=1 at any clock edge, including mid-operation, SHALL force IDLE, opReady=0, resValid=0, result=0, carry=0, counter=0, busy=0, done=0; reset dominates start and all transfers.

Configuration
REQ-031 Macro MULTI_WORD_ADD_SUB_EN defined: adds input port sub (1 bit, captured with start); when sub=1, opB SHALL be bit-inverted into the adder and the initial carry SHALL be !carryIn, giving A-B-borrow with carryOut=1 meaning no borrow.
REQ-032 Macro undefined: no sub port; addition only; behaviour identical to sub=0.

Structure
REQ-033 FSM state enum and state-encoding constants SHALL reside in shared package multi_word_add_pkg.
REQ-034 The word addition SHALL be one instance of the existing Adder sub-module (nrOfBits, extendedBits=nrOfBits+1); no other arithmetic in the block.

Verification
REQ-035 nrOfWords=4, nrOfBits=16, carryIn=0, A=0xFFFF_FFFF_FFFF_FFFF, B=0x0000_0000_0000_0001, resReady=1 -> results 0,0,0,0 on consecutive cycles, carryOut=1, done pulse one cycle after the last word.
REQ-036 Same operands, resReady held 0 for 3 cycles after word 1 -> opReady=0 during the stall, result=0x0000 stable, no word lost or duplicated.
REQ-037 Assert reset during the word-2 transfer -> next cycle busy=0, resValid=0, carryOut=0; a new start completes correctly.
REQ-038 nrOfWords=1, A=0x8000, B=0x8000, carryIn=1 -> result 0x0001, carryOut=1, done pulse.
REQ-039 SUB_EN defined, sub=1, carryIn=0, A=0x0000_0000_0000_0005, B=0x0000_0000_0000_0007 -> results 0xFFFE,0xFFFF,0xFFFF,0xFFFF, carryOut=0.
REQ-040 start pulsed in RUN -> ignored; counter and carry unchanged.
